bram_rd_streamer: RTL

//   Read-side engine for a simple dual-port BRAM: drives the BRAM read port (en/addr, 1-cycle

---
 rtl/bram_rd_pkg.sv | 5 +
 rtl/stream_fifo_sync.sv | 45 ++++
 rtl/bram_rd_streamer.sv | 109 ++++++++++
 3 files changed

// File: rtl/bram_rd_pkg.sv
// bram_rd_pkg: shared FSM state type and limits for the BRAM read streamer
package bram_rd_pkg;
  typedef enum logic [1:0] {RD_IDLE, RD_RUN, RD_DRAIN, RD_DONE} rd_state_e;
  localparam int INFLIGHT_MAX = 2;
endpackage

// File: rtl/stream_fifo_sync.sv
// stream_fifo_sync: synchronous FIFO, output read from registers (no path from push/pop to dout)
module stream_fifo_sync #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH <= 1) ? 1 : $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign empty = cnt_q == '0;
  assign full  = cnt_q == CW'(DEPTH);
  assign count = cnt_q;
  assign dout  = empty ? '0 : mem_q[rd_q];
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = do_push ? ((wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d    = do_pop ? ((rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/bram_rd_streamer.sv
// bram_rd_streamer: turns {base,len} into a valid/ready word stream from a 1-cycle BRAM.
// Optional m_last output enabled by defining BRAM_RD_LAST_EN.
module bram_rd_streamer
  import bram_rd_pkg::*;
#(
  parameter int DW = 16,
  parameter int DEPTH = 1024,
  parameter int AW = (DEPTH <= 1) ? 1 : $clog2(DEPTH),
  parameter int LW = AW + 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          b_en,
  output logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_dout,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data
`ifdef BRAM_RD_LAST_EN
  ,
  output logic          m_last
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(INFLIGHT_MAX + 1);
`ifdef BRAM_RD_LAST_EN
  localparam int FW = DW + 1;
`else
  localparam int FW = DW;
`endif
  rd_state_e state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] issue_q, issue_d, words_q, words_d;
  logic [IW-1:0] infl_q, infl_d;
  logic rd_vld_q, rd_vld_d;
  logic [CW-1:0] fifo_count;
  logic [FW-1:0] fifo_din, fifo_dout;
  logic fifo_empty, hs, accept;
  assign hs      = m_valid && m_ready;
  assign m_valid = !fifo_empty;
  assign b_addr  = addr_q;
  assign accept  = state_q == RD_IDLE && start;
`ifdef BRAM_RD_LAST_EN
  logic rd_last_q, rd_last_d;
  assign rd_last_d = b_en && issue_q == LW'(1);
  assign fifo_din = {rd_last_q, b_dout};
  assign {m_last, m_data} = fifo_dout;
  always_ff @(posedge clk) rd_last_q <= rst ? 1'b0 : rd_last_d;
`else
  assign fifo_din = b_dout;
  assign m_data   = fifo_dout;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RD_IDLE;
      addr_q   <= '0;
      issue_q  <= '0;
      words_q  <= '0;
      infl_q   <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      issue_q  <= issue_d;
      words_q  <= words_d;
      infl_q   <= infl_d;
      rd_vld_q <= rd_vld_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RD_IDLE:  if (start) state_d = (len == '0) ? RD_DONE : RD_RUN;
      RD_RUN:   if (b_en && issue_q == LW'(1)) state_d = RD_DRAIN;
      RD_DRAIN: if (hs && words_q == LW'(1)) state_d = RD_DONE;
      default:  state_d = RD_IDLE;
    endcase
  end
  // Issue only while buffered plus in-flight words still fit, so backpressure never drops data
  always_comb begin
    busy = state_q != RD_IDLE;
    done = state_q == RD_DONE;
    b_en = state_q == RD_RUN && (int'(fifo_count) + int'(infl_q)) < FIFO_DEPTH;
  end
  always_comb begin
    addr_d   = accept ? base_addr : b_en ? ((addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + 1'b1) : addr_q;
    issue_d  = accept ? len : b_en ? issue_q - 1'b1 : issue_q;
    words_d  = accept ? len : hs ? words_q - 1'b1 : words_q;
    infl_d   = infl_q + IW'(b_en) - IW'(rd_vld_q);
    rd_vld_d = b_en;
  end
  stream_fifo_sync #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_vld_q),
    .din   (fifo_din),
    .pop   (hs),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  ()
  );
endmodule
